// File: rtl/muldiv_unit.sv
// Iterative signed multiply / divide / remainder unit.
// One bit per cycle: shift-add for MUL, restoring division for DIV/REM,
// both on operand magnitudes with the sign fixed up when entering DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [25:0]      Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  // MUL: a_q = shifting multiplicand, b_q = shifting multiplier, acc_q = product
  // DIV: a_q = dividend shifting out / quotient shifting in, b_q = divisor,
  //      acc_q = partial remainder
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             neg_q;     // negate the magnitude result at the end
  logic             is_rem_q;  // DIV path returns the remainder
  logic             dbz_q;     // divisor was zero

  // Operation decode; MUL beats DIV beats REM when several bits are set,
  // so REM only applies when bit 24 is clear.
  logic op_mul, op_rem, op_any, accept, last;
  assign op_mul = Operation[23];
  assign op_rem = Operation[25] & ~Operation[24];
  assign op_any = |Operation[25:23];
  assign accept = (state_q == IDLE) & start & op_any;
  assign last   = (cnt_q == CW'(WIDTH-1));

  // Only bits 23..25 carry meaning for this unit.
  logic unused_op;
  assign unused_op = ^Operation[22:0];

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = SrcA[WIDTH-1] ? (~SrcA + 1'b1) : SrcA;
  assign mag_b = SrcB[WIDTH-1] ? (~SrcB + 1'b1) : SrcB;

  // One iteration of each datapath plus the sign-corrected final values.
  logic [WIDTH-1:0] mul_acc_n, mul_res;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n, div_quo_n, div_mag, div_res;

  // Combinational step of shift-add and restoring division.
  always_comb begin
    mul_acc_n = acc_q + (b_q[0] ? a_q : '0);
    mul_res   = neg_q ? (~mul_acc_n + 1'b1) : mul_acc_n;

    div_sh    = {acc_q, a_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, b_q};
    div_ge    = (div_sh >= {1'b0, b_q});
    div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo_n = {a_q[WIDTH-2:0], div_ge};
    div_mag   = is_rem_q ? div_rem_n : div_quo_n;
    div_res   = neg_q ? (~div_mag + 1'b1) : div_mag;
    // Divide by zero quotient is all ones regardless of operand signs; the
    // remainder path naturally yields SrcA because the dividend shifts
    // straight through when the divisor is zero.
    if (dbz_q && !is_rem_q) div_res = '1;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = op_mul ? MUL : DIV;
      MUL:  begin busy = 1'b1; if (last) state_d = DONE; end
      DIV:  begin busy = 1'b1; if (last) state_d = DONE; end
      DONE: begin done = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    stall = ~reset & (accept | busy);
  end

  // Operand capture, iteration and result update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      is_rem_q <= 1'b0;
      dbz_q    <= 1'b0;
      result   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          cnt_q    <= '0;
          a_q      <= mag_a;
          b_q      <= mag_b;
          acc_q    <= '0;
          is_rem_q <= ~op_mul & op_rem;
          neg_q    <= (~op_mul & op_rem) ? SrcA[WIDTH-1] : (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          dbz_q    <= (SrcB == '0);
        end
        MUL: begin
          acc_q <= mul_acc_n;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) result <= mul_res;
        end
        DIV: begin
          acc_q <= div_rem_n;
          a_q   <= div_quo_n;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) result <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [25:0]  Operation;
  logic [W-1:0] SrcA, SrcB;
  logic [W-1:0] result;
  logic         busy, done, stall;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  localparam logic [25:0] OP_MUL = 26'h1 << 23;
  localparam logic [25:0] OP_DIV = 26'h1 << 24;
  localparam logic [25:0] OP_REM = 26'h1 << 25;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .result(result), .busy(busy),
    .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: signed arithmetic on wide integers.
  function automatic logic [W-1:0] model(input logic [25:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    if (op[23]) begin
      p = sa * sb;
    end else if (b == '0) begin
      p = op[24] ? -64'sd1 : sa;
    end else begin
      p = op[24] ? (sa / sb) : (sa % sb);
    end
    return p[W-1:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: result %0h with nothing outstanding", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  // Launch one op, scramble inputs during iteration, check timing/handshake.
  // inject > 0 re-asserts start with a MUL at that cycle of the iteration.
  task automatic run_op(input logic [25:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int inject);
    int n, bc, d0;
    bit seen;
    @(negedge clk);
    start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    #1 chk("stall_on_start", stall, 1'b1);
    exp_q.push_back(exp);
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    n = 0; bc = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) seen = 1;
      if (inject > 0 && n == inject) begin
        start = 1'b1; Operation = OP_MUL; SrcA = 32'd5; SrcB = 32'd6;
      end else if (inject > 0 && n == inject + 1) begin
        start = 1'b0;
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("latency", n, 33);
    chk("busy_cycles", bc, 32);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 40) - 20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [25:0] op;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b1; Operation = OP_MUL; SrcA = 32'd3; SrcB = 32'd4;
    #12;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with hand-computed expectations.
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0);
    run_op(OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
    run_op(OP_DIV, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0);
    run_op(OP_REM, 32'h1234_5678, 32'h0, 32'h1234_5678, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    // Priority: all three set -> MUL; DIV+REM -> DIV.
    run_op(OP_MUL | OP_DIV | OP_REM, 32'd9, 32'd11, 32'd99, 0);
    run_op(OP_DIV | OP_REM, 32'd100, 32'd7, 32'd14, 0);
    // New MUL during an active DIV is ignored.
    run_op(OP_DIV, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 5);

    // start with no relevant op bit is ignored.
    @(negedge clk);
    start = 1'b1; Operation = 26'h12_3456;
    #1 chk("noop_stall", stall, 1'b0);
    chk("noop_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("noop_busy_later", busy, 1'b0);
    start = 1'b0;

    // Reset mid-MUL aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; Operation = OP_MUL; SrcA = 32'd123; SrcB = 32'd456;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b1; start = 1'b1;
    #1 chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b0; reset = 1'b0;
    run_op(OP_MUL, 32'd5, 32'd6, 32'd30, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      case ($urandom_range(0, 2))
        0: op = OP_MUL;
        1: op = OP_DIV;
        default: op = OP_REM;
      endcase
      op = op | ($urandom & 26'h7F_FFFF);
      run_op(op, a, b, model(op, a, b), 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
